uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Asynchronous serial (8N1) receiver for the control-FPGA host link. Recovers bytes from the host-side RX pin and pushes each valid byte into the downstream `fifo` input channel using the FIFO's write/full handshake. Runs on the system clock with a fixed integer bit period. Reports framing errors and FIFO overruns as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 417: clocks per serial bit (48 MHz / 115200); legal range 4 to 2^CNT_WIDTH−1.
- `CNT_WIDTH`, default 16: width of the bit-period counter.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `i_full`  in  1  from FIFO `o_full`.
- `o_data`  out  8  received byte, to FIFO `i_data`; reset 0.
- `o_write_enable`  out  1  one-cycle push strobe, to FIFO `i_write_enable`; reset 0.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0.
- `o_overrun`  out  1  one-cycle pulse: valid byte dropped because `i_full`=1; reset 0.
- `o_busy`  out  1  high in any state other than IDLE; reset 0.

## Operation
- `i_rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the second flop output `rx_s`.
- HALF = CLKS_PER_BIT/2, integer floor.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE, counter 0, bit index 0, shift register 0.
- IDLE: when `rx_s`=0, go to START with counter 0.
- START: counter increments each cycle. At counter==HALF−1, sample `rx_s`.
  - Sample 0: go to DATA with counter 0 and bit index 0.
  - Sample 1: false start; return to IDLE. No outputs are asserted.
- DATA: at counter==CLKS_PER_BIT−1, shift `rx_s` in LSB-first and reset the counter. After the 8th bit, go to STOP with counter 0.
- STOP: at counter==CLKS_PER_BIT−1, sample `rx_s`.
  - Sample 1, `i_full`=0: register the byte on `o_data` and pulse `o_write_enable`. Go to IDLE.
  - Sample 1, `i_full`=1: pulse `o_overrun`. `o_data` is unchanged and the byte is discarded. Go to IDLE.
  - Sample 0: pulse `o_frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE (break or misaligned line): stay until `rx_s`=1, then go to IDLE. A new start bit can be detected only after the line returns high.
- `o_data` holds the last pushed byte until the next push. It changes only in the cycle `o_write_enable` is asserted.
- `o_write_enable`, `o_frame_err` and `o_overrun` are mutually exclusive. Each is high for exactly one cycle per byte.
- `i_full` is sampled only in the stop-sample cycle; `i_full` at any other time has no effect.
- Reset asserted mid-frame: all outputs go to reset values immediately and the partial byte is lost. After release, a line held low is treated as a start bit, sampled at HALF; stop-bit checking then catches misalignment.

## Timing
- Synchronizer latency: 2 clocks from an `i_rx` edge to `rx_s`.
- Start-bit check: the START sample occurs HALF cycles after the first low `rx_s` cycle.
- Data sampling: data bit k is sampled HALF + (k+1)·CLKS_PER_BIT cycles after the first low `rx_s` cycle, for k = 0..7.
- Stop sampling: the stop bit is sampled at HALF + 9·CLKS_PER_BIT.
- Output registration: `o_write_enable`, `o_overrun` or `o_frame_err` is asserted in the cycle after the stop sample, registered.
- `o_busy` rises the cycle after `rx_s` first goes low. It falls in the same cycle as the result pulse, or when leaving WAIT_IDLE.
- Back-to-back frames: a start bit beginning immediately after a 1-bit stop is received without loss. IDLE is re-entered about half a bit before the next falling edge.
- Throughput: at most one push per 10·CLKS_PER_BIT cycles, so the FIFO never sees consecutive-cycle writes.

## Test plan
- CLKS_PER_BIT=8, send 0xA5 framed 8N1 with `i_full`=0 → exactly one `o_write_enable` pulse, `o_data`=0xA5 on that cycle, no error pulses, `o_busy` low afterward.
- Send 0x00 then 0xFF back-to-back with no idle gap → two pushes with data 0x00 then 0xFF, about 80 cycles apart, no errors.
- Glitch `i_rx` low for 2 cycles from idle (shorter than HALF=4) → `o_busy` pulses briefly, no write and no error pulse, returns to IDLE.
- Send 0x3C with stop bit driven low, hold low 30 cycles, release → one `o_frame_err` pulse, no write; the next valid frame 0x5A after release is pushed correctly.
- Hold `i_full`=1 and send 0x77 → one `o_overrun` pulse, no `o_write_enable`, `o_data` keeps its previous value. Clear `i_full` and send 0x11 → push of 0x11.
- Assert `reset_n` low during bit 4 of a frame, release, drive the line idle, then send 0xC3 → all outputs 0 during reset, no spurious pulse after release, 0xC3 pushed.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: recovers bytes from the host RX pin and pushes them into a FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 417,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx,
  input  logic       i_full,
  output logic [7:0] o_data,
  output logic       o_write_enable,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_M1  = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [1:0]           sync_r;
  logic                 rx_s;
  state_t               state_r, state_next_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
  logic [2:0]           bit_idx_r, bit_idx_next_s;
  logic [7:0]           shift_r, shift_next_s;
  logic [7:0]           data_r, data_next_s;
  logic                 we_r, we_next_s;
  logic                 fe_r, fe_next_s;
  logic                 ovr_r, ovr_next_s;
  logic                 busy_r, busy_next_s;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], i_rx};
    end
  end

  // Next-state, datapath and result-pulse logic.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    data_next_s    = data_r;
    we_next_s      = 1'b0;
    fe_next_s      = 1'b0;
    ovr_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next_s = ST_START;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_next_s = '0;
          if (!rx_s) begin
            state_next_s   = ST_DATA;
            bit_idx_next_s = 3'd0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_M1) begin
          cnt_next_s   = '0;
          shift_next_s = {rx_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_next_s   = ST_STOP;
            bit_idx_next_s = 3'd0;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_M1) begin
          cnt_next_s = '0;
          if (rx_s) begin
            state_next_s = ST_IDLE;
            if (!i_full) begin
              data_next_s = shift_r;
              we_next_s   = 1'b1;
            end else begin
              ovr_next_s = 1'b1;
            end
          end else begin
            // Stop bit low: break or misaligned frame, wait for the line to recover.
            state_next_s = ST_WAIT_IDLE;
            fe_next_s    = 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      we_r      <= 1'b0;
      fe_r      <= 1'b0;
      ovr_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      data_r    <= data_next_s;
      we_r      <= we_next_s;
      fe_r      <= fe_next_s;
      ovr_r     <= ovr_next_s;
      busy_r    <= busy_next_s;
    end
  end

  assign o_data         = data_r;
  assign o_write_enable = we_r;
  assign o_frame_err    = fe_r;
  assign o_overrun      = ovr_r;
  assign o_busy         = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit: table of framed bytes plus
// hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_byte;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_full = 1'b0;
  logic [7:0] o_data;
  logic       o_write_enable;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_rx(i_rx), .i_full(i_full),
    .o_data(o_data), .o_write_enable(o_write_enable), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Output monitor: pulse counts, push log, exclusivity and o_data stability.
  int         n_we = 0, n_fe = 0, n_ovr = 0, n_busy = 0, excl_err = 0, chg_err = 0, cyc = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] we_data_q[$];
  int         we_cyc_q[$];
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (o_write_enable) begin
        n_we++;
        we_data_q.push_back(o_data);
        we_cyc_q.push_back(cyc);
      end
      if (o_frame_err) n_fe++;
      if (o_overrun) n_ovr++;
      if (o_busy) n_busy++;
      if ((int'(o_write_enable) + int'(o_frame_err) + int'(o_overrun)) > 1) excl_err++;
      if (!o_write_enable && (o_data !== prev_data)) chg_err++;
    end
    prev_data = o_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive start + 8 data bits LSB-first; stop bit high for one bit, or low for one bit plus extra.
  task automatic send_frame(input logic [7:0] b, input logic stop_hi, input int low_extra);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    if (stop_hi) begin
      i_rx = 1'b1;
      tick(CPB);
    end else begin
      i_rx = 1'b0;
      tick(CPB + low_extra);
      i_rx = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_hi;
    logic       full;
    int         exp_we;
    int         exp_fe;
    int         exp_ovr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b_we, b_fe, b_ovr, b_busy, q0;
    logic [7:0] c3_bits;

    vecs[0] = '{data: 8'hA5, stop_hi: 1'b1, full: 1'b0, exp_we: 1, exp_fe: 0, exp_ovr: 0, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop_hi: 1'b0, full: 1'b0, exp_we: 0, exp_fe: 1, exp_ovr: 0, exp_data: 8'hA5};
    vecs[2] = '{data: 8'h5A, stop_hi: 1'b1, full: 1'b0, exp_we: 1, exp_fe: 0, exp_ovr: 0, exp_data: 8'h5A};
    vecs[3] = '{data: 8'h77, stop_hi: 1'b1, full: 1'b1, exp_we: 0, exp_fe: 0, exp_ovr: 1, exp_data: 8'h5A};
    vecs[4] = '{data: 8'h11, stop_hi: 1'b1, full: 1'b0, exp_we: 1, exp_fe: 0, exp_ovr: 0, exp_data: 8'h11};

    // Reset state
    tick(3);
    chk("reset_data", 32'(o_data), 32'h0);
    chk("reset_we", 32'(o_write_enable), 32'h0);
    chk("reset_fe", 32'(o_frame_err), 32'h0);
    chk("reset_ovr", 32'(o_overrun), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      b_we = n_we; b_fe = n_fe; b_ovr = n_ovr; q0 = we_data_q.size();
      i_full = vecs[v].full;
      send_frame(vecs[v].data, vecs[v].stop_hi, 30);
      tick(6);
      i_full = 1'b0;
      chk($sformatf("v%0d_we_count", v), 32'(n_we - b_we), 32'(vecs[v].exp_we));
      chk($sformatf("v%0d_fe_count", v), 32'(n_fe - b_fe), 32'(vecs[v].exp_fe));
      chk($sformatf("v%0d_ovr_count", v), 32'(n_ovr - b_ovr), 32'(vecs[v].exp_ovr));
      chk($sformatf("v%0d_data", v), 32'(o_data), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_busy_after", v), 32'(o_busy), 32'h0);
      if (vecs[v].exp_we == 1 && we_data_q.size() > q0)
        chk($sformatf("v%0d_data_at_push", v), 32'(we_data_q[q0]), 32'(vecs[v].data));
    end

    // Back-to-back 0x00 then 0xFF with no idle gap
    b_we = n_we; b_fe = n_fe; q0 = we_data_q.size();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    tick(6);
    chk("b2b_we_count", 32'(n_we - b_we), 32'd2);
    chk("b2b_fe_count", 32'(n_fe - b_fe), 32'd0);
    if (we_data_q.size() >= q0 + 2) begin
      chk("b2b_first", 32'(we_data_q[q0]), 32'h00);
      chk("b2b_second", 32'(we_data_q[q0 + 1]), 32'hFF);
      chk("b2b_spacing", 32'(we_cyc_q[q0 + 1] - we_cyc_q[q0]), 32'd80);
    end else begin
      chk("b2b_push_log", 32'(we_data_q.size() - q0), 32'd2);
    end

    // Glitch shorter than half a bit
    b_we = n_we; b_fe = n_fe; b_ovr = n_ovr; b_busy = n_busy;
    i_rx = 1'b0;
    tick(2);
    i_rx = 1'b1;
    tick(12);
    chk("glitch_busy_seen", 32'(n_busy > b_busy), 32'd1);
    chk("glitch_no_pulse", 32'((n_we - b_we) + (n_fe - b_fe) + (n_ovr - b_ovr)), 32'd0);
    chk("glitch_busy_after", 32'(o_busy), 32'h0);
    chk("glitch_data_kept", 32'(o_data), 32'hFF);

    // Reset during bit 4, then a clean 0xC3
    i_rx = 1'b0;
    tick(CPB);
    c3_bits = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      i_rx = c3_bits[i];
      tick(CPB);
    end
    i_rx = c3_bits[4];
    tick(CPB / 2);
    reset_n = 1'b0;
    #1;
    chk("midrst_data", 32'(o_data), 32'h0);
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_pulses", 32'({o_write_enable, o_frame_err, o_overrun}), 32'h0);
    tick(3);
    i_rx = 1'b1;
    tick(2);
    reset_n = 1'b1;
    b_we = n_we; b_fe = n_fe; b_ovr = n_ovr;
    tick(20);
    chk("postrst_no_pulse", 32'((n_we - b_we) + (n_fe - b_fe) + (n_ovr - b_ovr)), 32'd0);
    chk("postrst_busy", 32'(o_busy), 32'h0);
    q0 = we_data_q.size();
    send_frame(8'hC3, 1'b1, 0);
    tick(6);
    chk("postrst_we_count", 32'(n_we - b_we), 32'd1);
    chk("postrst_data", 32'(o_data), 32'hC3);
    if (we_data_q.size() > q0) chk("postrst_data_at_push", 32'(we_data_q[q0]), 32'hC3);

    chk("pulse_exclusive", 32'(excl_err), 32'd0);
    chk("data_only_on_push", 32'(chg_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
